// File: rtl/fft_spectrum_sink.sv
// Receive-side sink for the FFT output stream: squares and sums each complex bin,
// buffers one frame of magnitudes, tracks the peak bin, and holds the frame until acknowledged.
module fft_spectrum_sink #(
   parameter  int FFT_SIZE   = 16,
   parameter  int DATA_WIDTH = 16,
   localparam int MAG_WIDTH  = 2 * DATA_WIDTH,
   localparam int LOG2_N     = $clog2(FFT_SIZE)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    fft_valid_i,
   input  logic [2*DATA_WIDTH-1:0] fft_data_i,
   output logic                    fft_ready_o,
   input  logic                    rd_req_i,
   input  logic [LOG2_N-1:0]       rd_addr_i,
   output logic                    rd_valid_o,
   output logic [MAG_WIDTH-1:0]    rd_data_o,
   output logic                    frame_done_o,
   output logic [LOG2_N-1:0]       peak_bin_o,
   output logic [MAG_WIDTH-1:0]    peak_mag_o,
   input  logic                    frame_ack_i,
   output logic                    busy_o
);

   typedef enum logic [1:0] {
      S_COLLECT,
      S_DRAIN,
      S_HOLD
   } state_e;

   state_e state_q, state_d;

   logic [LOG2_N-1:0]           cnt_q;
   logic                        hs, last_hs, ack;
   logic signed [DATA_WIDTH-1:0] re, im;
   logic signed [MAG_WIDTH-1:0] re_x, im_x, re_prod, im_prod;
   logic [MAG_WIDTH-1:0]        re_sq_q, im_sq_q, mag;
   logic                        p_valid_q, p_last_q;
   logic [LOG2_N-1:0]           p_addr_q;
   logic [MAG_WIDTH-1:0]        mem [FFT_SIZE];
   logic                        frame_done_q, rd_valid_q;
   logic [MAG_WIDTH-1:0]        rd_data_q, peak_mag_q;
   logic [LOG2_N-1:0]           peak_bin_q;

   assign re      = fft_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
   assign im      = fft_data_i[DATA_WIDTH-1:0];
   // Sign-extend before multiplying so the square is formed at full magnitude width.
   assign re_x    = MAG_WIDTH'(re);
   assign im_x    = MAG_WIDTH'(im);
   assign re_prod = re_x * re_x;
   assign im_prod = im_x * im_x;
   assign mag     = re_sq_q + im_sq_q;

   assign hs      = fft_valid_i & fft_ready_o;
   assign last_hs = hs && (cnt_q == LOG2_N'(FFT_SIZE - 1));
   assign ack     = (state_q == S_HOLD) && frame_ack_i;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_COLLECT;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_COLLECT: if (last_hs)     state_d = S_DRAIN;
         S_DRAIN:   if (p_last_q)    state_d = S_HOLD;
         S_HOLD:    if (frame_ack_i) state_d = S_COLLECT;
         default:                    state_d = S_COLLECT;
      endcase
   end

   always_comb begin
      fft_ready_o = 1'b0;
      busy_o      = 1'b0;
      unique case (state_q)
         S_COLLECT: begin
            fft_ready_o = 1'b1;
            busy_o      = (cnt_q != '0);
         end
         S_DRAIN:   busy_o = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         p_valid_q <= 1'b0;
         p_last_q  <= 1'b0;
         p_addr_q  <= '0;
         re_sq_q   <= '0;
         im_sq_q   <= '0;
      end else begin
         if (ack)     cnt_q <= '0;
         else if (hs) cnt_q <= cnt_q + 1'b1;
         p_valid_q <= hs;
         p_last_q  <= last_hs;
         p_addr_q  <= cnt_q;
         if (hs) begin
            re_sq_q <= $unsigned(re_prod);
            im_sq_q <= $unsigned(im_prod);
         end
      end
   end

   // NOTE: the magnitude buffer has no reset; it is plain storage and only written by the pipeline.
   always_ff @(posedge clk_i) begin
      if (p_valid_q) mem[p_addr_q] <= mag;
   end

   // Strict compare keeps the lowest index on ties; the ack edge starts a fresh frame at zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         peak_bin_q   <= '0;
         peak_mag_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         if (ack) begin
            peak_bin_q <= '0;
            peak_mag_q <= '0;
         end else if (p_valid_q && (mag > peak_mag_q)) begin
            peak_bin_q <= p_addr_q;
            peak_mag_q <= mag;
         end
         frame_done_q <= p_valid_q & p_last_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_req_i;
         if (rd_req_i) rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_valid_o   = rd_valid_q;
   assign rd_data_o    = rd_data_q;
   assign frame_done_o = frame_done_q;
   assign peak_bin_o   = peak_bin_q;
   assign peak_mag_o   = peak_mag_q;

endmodule

// File: tb/tb_fft_spectrum_sink.sv
// Self-checking bench for fft_spectrum_sink: a cycle-level predictor built from frame/bin
// bookkeeping is compared against the DUT every cycle, plus literal expectations for directed frames.
module tb_fft_spectrum_sink;
   localparam int N  = 16;
   localparam int DW = 16;
   localparam int MW = 2 * DW;
   localparam int LN = 4;

   logic            clk_i = 1'b1;
   logic            rst_ni = 1'b0;
   logic            fft_valid_i = 1'b0;
   logic [2*DW-1:0] fft_data_i = '0;
   logic            fft_ready_o;
   logic            rd_req_i = 1'b0;
   logic [LN-1:0]   rd_addr_i = '0;
   logic            rd_valid_o;
   logic [MW-1:0]   rd_data_o;
   logic            frame_done_o;
   logic [LN-1:0]   peak_bin_o;
   logic [MW-1:0]   peak_mag_o;
   logic            frame_ack_i = 1'b0;
   logic            busy_o;

   fft_spectrum_sink #(.FFT_SIZE(N), .DATA_WIDTH(DW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .fft_valid_i(fft_valid_i), .fft_data_i(fft_data_i),
      .fft_ready_o(fft_ready_o), .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
      .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .frame_done_o(frame_done_o),
      .peak_bin_o(peak_bin_o), .peak_mag_o(peak_mag_o), .frame_ack_i(frame_ack_i),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   longint fr_mag [N];
   int     fr_edge[N];
   longint mem_cur[N], mem_prev[N];
   bit     cur_known[N], prev_known[N];
   int     mem_wedge[N];
   int     n_acc = 0, last_edge = -100, cyc = 0;
   bit     exp_ready = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
   bit     exp_rd_valid = 1'b0, exp_rd_known = 1'b1;
   longint exp_rd_data = 0, exp_peak_mag = 0;
   int     exp_peak_bin = 0;

   initial begin
      for (int a = 0; a < N; a++) begin
         cur_known[a] = 1'b0; prev_known[a] = 1'b0; mem_wedge[a] = -1;
         mem_cur[a] = 0; mem_prev[a] = 0;
      end
   end

   // Outputs are compared at each falling edge; then the next rising edge is predicted from the inputs.
   always @(negedge clk_i) begin : cmp
      int e, a;
      longint re, im;
      if (!rst_ni) begin
         exp_ready = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_rd_valid = 1'b0;
         exp_rd_data = 0; exp_rd_known = 1'b1; exp_peak_bin = 0; exp_peak_mag = 0;
      end
      check("ready", fft_ready_o, exp_ready);
      check("busy", busy_o, exp_busy);
      check("frame_done", frame_done_o, exp_done);
      check("rd_valid", rd_valid_o, exp_rd_valid);
      if (exp_rd_known) check("rd_data", rd_data_o, exp_rd_data);
      check("peak_bin", peak_bin_o, exp_peak_bin);
      check("peak_mag", peak_mag_o, exp_peak_mag);

      e = cyc + 1;
      cyc = e;
      if (!rst_ni) begin
         for (int k = 0; k < N; k++)
            if (mem_wedge[k] >= e) begin
               mem_cur[k] = mem_prev[k]; cur_known[k] = prev_known[k]; mem_wedge[k] = -1;
            end
         n_acc = 0;
         last_edge = -100;
      end else begin
         if (rd_req_i) begin
            a = int'(rd_addr_i);
            exp_rd_valid = 1'b1;
            if (mem_wedge[a] < e) begin exp_rd_data = mem_cur[a];  exp_rd_known = cur_known[a];  end
            else                  begin exp_rd_data = mem_prev[a]; exp_rd_known = prev_known[a]; end
         end else begin
            exp_rd_valid = 1'b0;
         end
         exp_done = (n_acc == N) && (e == last_edge + 1);
         if (frame_ack_i && n_acc == N && e >= last_edge + 2) begin
            n_acc = 0;
         end else if (fft_valid_i && n_acc < N) begin
            re = longint'($signed(fft_data_i[2*DW-1:DW]));
            im = longint'($signed(fft_data_i[DW-1:0]));
            fr_mag[n_acc]  = re * re + im * im;
            fr_edge[n_acc] = e;
            mem_prev[n_acc]   = mem_cur[n_acc];
            prev_known[n_acc] = cur_known[n_acc];
            mem_cur[n_acc]    = fr_mag[n_acc];
            cur_known[n_acc]  = 1'b1;
            mem_wedge[n_acc]  = e + 1;
            if (n_acc == N - 1) last_edge = e;
            n_acc++;
         end
         exp_ready = (n_acc < N);
         exp_busy  = (n_acc > 0 && n_acc < N) || (n_acc == N && last_edge == e);
         exp_peak_bin = 0;
         exp_peak_mag = 0;
         for (int i = 0; i < n_acc; i++)
            if (fr_edge[i] + 1 <= e && fr_mag[i] > exp_peak_mag) begin
               exp_peak_mag = fr_mag[i]; exp_peak_bin = i;
            end
      end
   end

   // ---------------- stimulus ----------------
   logic [DW-1:0] q_re[$], q_im[$];
   bit rand_rd = 1'b0, rand_ack = 1'b0, rand_gap = 1'b0;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input int re, input int im);
      q_re.push_back(DW'(re));
      q_im.push_back(DW'(im));
   endtask

   function automatic logic [DW-1:0] rnd_sample();
      if ($urandom_range(0, 7) == 0) return 16'h8000;
      return DW'($urandom);
   endfunction

   // Leaves fft_valid_i as last driven so a caller can hold valid across the frame boundary.
   task automatic send(input int n_bins);
      int sent = 0;
      int budget = 0;
      bit hs;
      while (sent < n_bins) begin
         fft_data_i  = {q_re[0], q_im[0]};
         fft_valid_i = rand_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
         rd_req_i    = rand_rd ? 1'($urandom_range(0, 1)) : 1'b0;
         rd_addr_i   = LN'($urandom_range(0, N - 1));
         frame_ack_i = rand_ack ? ($urandom_range(0, 5) == 0) : 1'b0;
         @(negedge clk_i);
         hs = fft_valid_i && fft_ready_o;
         tick();
         if (hs) begin
            void'(q_re.pop_front());
            void'(q_im.pop_front());
            sent++;
         end
         budget++;
         if (budget > 200) begin
            check("send_timeout", sent, n_bins);
            break;
         end
      end
      frame_ack_i = 1'b0;
      rd_req_i    = 1'b0;
   endtask

   // Returns at the falling edge of the frame_done cycle.
   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (frame_done_o) begin
            seen = 1'b1;
            break;
         end
      end
      check("frame_done_seen", seen, 1);
   endtask

   task automatic readback();
      for (int a = 0; a < N; a++) begin
         rd_req_i  = 1'b1;
         rd_addr_i = LN'(a);
         tick();
      end
      rd_req_i = 1'b0;
      tick();
   endtask

   task automatic do_ack();
      frame_ack_i = 1'b1;
      tick();
      frame_ack_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check("rst_ready_lit", fft_ready_o, 1);
      check("rst_peak_lit", peak_mag_o, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("post_rst_ready_lit", fft_ready_o, 1);
      tick();

      // Ramp frame: re = k, im = 0.
      for (int k = 0; k < N; k++) push(k, 0);
      send(N);
      fft_valid_i = 1'b0;
      wait_done();
      check("A_peak_bin_lit", peak_bin_o, 15);
      check("A_peak_mag_lit", peak_mag_o, 225);
      check("A_model_peak_lit", exp_peak_mag, 225);
      tick();
      readback();
      do_ack();

      // Extreme negative bin at index 3.
      for (int k = 0; k < N; k++) if (k == 3) push(-32768, -32768); else push(1, 1);
      send(N);
      fft_valid_i = 1'b0;
      wait_done();
      check("B_peak_bin_lit", peak_bin_o, 3);
      tick();
      readback();
      rd_req_i = 1'b1; rd_addr_i = 4'd3;
      tick();
      rd_req_i = 1'b0;
      @(negedge clk_i);
      check("B_bin3_lit", rd_data_o, 64'h8000_0000);
      check("B_model_bin3_lit", exp_rd_data, 64'h8000_0000);
      tick();
      do_ack();

      // Tie between bins 5 and 9.
      for (int k = 0; k < N; k++)
         if (k == 5 || k == 9) push(300, -400);
         else push($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100);
      send(N);
      fft_valid_i = 1'b0;
      wait_done();
      check("C_peak_bin_lit", peak_bin_o, 5);
      check("C_peak_mag_lit", peak_mag_o, 250000);
      check("C_model_bin_lit", exp_peak_bin, 5);
      tick();
      do_ack();

      // Valid held through a 17th bin across HOLD and the ack.
      for (int k = 0; k < N; k++) push(int'(rnd_sample()), int'(rnd_sample()));
      push(7, 7);
      send(N);
      fft_data_i = {q_re[0], q_im[0]};
      wait_done();
      tick();
      repeat (3) tick();
      do_ack();
      send(1);
      fft_valid_i = 1'b0;
      @(negedge clk_i);
      check("D_peak_cleared_lit", peak_mag_o, 0);
      tick();
      @(negedge clk_i);
      check("D_bin0_peak_lit", peak_mag_o, 98);
      tick();
      for (int k = 1; k < N; k++) push(int'(rnd_sample()), int'(rnd_sample()));
      send(N - 1);
      fft_valid_i = 1'b0;
      wait_done();
      tick();
      readback();
      do_ack();

      // Reset in the middle of a frame.
      for (int k = 0; k < 7; k++) push(int'(rnd_sample()), int'(rnd_sample()));
      send(7);
      rst_ni = 1'b0;
      fft_valid_i = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("E_busy_lit", busy_o, 0);
      check("E_ready_lit", fft_ready_o, 1);
      tick();

      // Randomized frames with gaps, random reads and stray acks.
      rand_rd = 1'b1; rand_ack = 1'b1; rand_gap = 1'b1;
      for (int f = 0; f < 7; f++) begin
         for (int k = 0; k < N; k++) push(int'(rnd_sample()), int'(rnd_sample()));
         send(N);
         fft_valid_i = 1'b0;
         wait_done();
         tick();
         readback();
         repeat ($urandom_range(0, 3)) tick();
         do_ack();
      end

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
